// File: rtl/fetch_pkg.sv
// Shared core constants: opcode, ALU and writeback encodings, plus fetch FSM states and the NOP word.
package fetch_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;
  localparam logic [1:0] WB_IMM = 2'd3;

  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [1:0] S_DROP = 2'd3;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage

// File: rtl/fetch.sv
// Instruction fetch: one outstanding imem request, redirect handling, and a held output register toward decode.
module fetch
  import fetch_pkg::*;
#(
  parameter int               DWIDTH   = 32,
  parameter int               AWIDTH   = 32,
  parameter logic [AWIDTH-1:0] BASEADDR = 32'h0100_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req_o,
  output logic [AWIDTH-1:0] imem_addr_o,
  input  logic              imem_rvalid_i,
  input  logic [DWIDTH-1:0] imem_rdata_i,
  input  logic              redirect_i,
  input  logic [AWIDTH-1:0] redirect_pc_i,
  output logic              dec_valid_o,
  input  logic              dec_ready_i,
  output logic [AWIDTH-1:0] dec_pc_o,
  output logic [DWIDTH-1:0] dec_insn_o
);

  logic [1:0]        state;
  logic [AWIDTH-1:0] pc;
  logic [AWIDTH-1:0] target;

  assign target = redirect_pc_i & ~AWIDTH'(3);

  // Gating with rst_n keeps the request low while reset holds state at REQ.
  assign imem_req_o  = rst_n && (state == S_REQ);
  assign imem_addr_o = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_REQ;
      pc          <= BASEADDR;
      dec_valid_o <= 1'b0;
      dec_pc_o    <= BASEADDR;
      dec_insn_o  <= DWIDTH'(NOP_INSN);
    end else begin
      case (state)
        S_REQ: begin
          // The request still goes out; its response must be dropped after a redirect.
          if (redirect_i) begin
            pc    <= target;
            state <= S_DROP;
          end else begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (redirect_i) begin
            pc    <= target;
            state <= imem_rvalid_i ? S_REQ : S_DROP;
          end else if (imem_rvalid_i) begin
            dec_insn_o  <= imem_rdata_i;
            dec_pc_o    <= pc;
            dec_valid_o <= 1'b1;
            pc          <= pc + AWIDTH'(4);
            state       <= S_HOLD;
          end
        end
        S_HOLD: begin
          // Redirect wins over the handshake; pc was already advanced in WAIT.
          if (redirect_i) begin
            dec_valid_o <= 1'b0;
            pc          <= target;
            state       <= S_REQ;
          end else if (dec_ready_i) begin
            dec_valid_o <= 1'b0;
            state       <= S_REQ;
          end
        end
        S_DROP: begin
          if (redirect_i) pc <= target;
          if (imem_rvalid_i) state <= S_REQ;
        end
        default: state <= S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch.sv
// Directed bench for fetch: streaming, stalls, redirects in each state, pc wrap and mid-request reset.
module tb_fetch;

  localparam logic [31:0] BASE = 32'h0100_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        dec_valid_o;
  logic        dec_ready_i;
  logic [31:0] dec_pc_o;
  logic [31:0] dec_insn_o;

  int errors = 0;
  int checks = 0;

  // Auto memory responder state, advanced inside step().
  bit          auto_mem = 1'b0;
  int          lat = 1;
  int          cnt = 0;
  logic [31:0] paddr;

  fetch #(.DWIDTH(32), .AWIDTH(32), .BASEADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .dec_valid_o(dec_valid_o), .dec_ready_i(dec_ready_i),
    .dec_pc_o(dec_pc_o), .dec_insn_o(dec_insn_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] insn_of(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  // Drive this cycle's memory response, then advance to 1 time unit after the next rising edge.
  task automatic step();
    if (auto_mem) begin
      imem_rvalid_i = 1'b0;
      if (cnt > 0) begin
        cnt = cnt - 1;
        if (cnt == 0) begin
          imem_rvalid_i = 1'b1;
          imem_rdata_i  = insn_of(paddr);
        end
      end
      if (imem_req_o) begin
        paddr = imem_addr_o;
        cnt   = lat;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;
    redirect_i = 1'b0; redirect_pc_i = '0; dec_ready_i = 1'b1;
    @(posedge clk); #1; @(posedge clk); #1;
    checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", imem_req_o); end
    checks++; if (dec_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", dec_valid_o); end
    checks++; if (dec_pc_o !== BASE) begin errors++; $display("FAIL rst_pc: got %h want %h", dec_pc_o, BASE); end
    checks++; if (dec_insn_o !== 32'h0000_0013) begin errors++; $display("FAIL rst_insn: got %h want 00000013", dec_insn_o); end
    rst_n = 1'b1;
    #1;
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== BASE) begin errors++; $display("FAIL first_req: req %b addr %h want 1 %h", imem_req_o, imem_addr_o, BASE); end
  endtask

  task automatic test_stream();
    logic [31:0] a;
    auto_mem = 1'b1; lat = 1; cnt = 0; dec_ready_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      a = BASE + 32'(4 * k);
      checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== a) begin errors++; $display("FAIL stream_req%0d: req %b addr %h want 1 %h", k, imem_req_o, imem_addr_o, a); end
      step();
      checks++; if (imem_req_o !== 1'b0 || dec_valid_o !== 1'b0) begin errors++; $display("FAIL stream_wait%0d: req %b valid %b want 0 0", k, imem_req_o, dec_valid_o); end
      step();
      checks++; if (dec_valid_o !== 1'b1 || dec_pc_o !== a || dec_insn_o !== insn_of(a)) begin
        errors++; $display("FAIL stream_dec%0d: valid %b pc %h insn %h want 1 %h %h", k, dec_valid_o, dec_pc_o, dec_insn_o, a, insn_of(a)); end
      step();
    end
  endtask

  task automatic test_hold_stall();
    dec_ready_i = 1'b0;
    checks++; if (imem_addr_o !== 32'h0100_000C) begin errors++; $display("FAIL stall_req: addr %h want 0100000c", imem_addr_o); end
    step(); step();
    for (int i = 0; i < 5; i++) begin
      checks++; if (dec_valid_o !== 1'b1 || dec_pc_o !== 32'h0100_000C || dec_insn_o !== 32'hDFAD_000C || imem_req_o !== 1'b0) begin
        errors++; $display("FAIL stall_hold%0d: valid %b pc %h insn %h req %b want 1 0100000c dfad000c 0", i, dec_valid_o, dec_pc_o, dec_insn_o, imem_req_o); end
      step();
    end
    dec_ready_i = 1'b1;
    step();
    checks++; if (dec_valid_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h0100_0010) begin
      errors++; $display("FAIL stall_release: valid %b req %b addr %h want 0 1 01000010", dec_valid_o, imem_req_o, imem_addr_o); end
  endtask

  task automatic test_redirect_wait();
    lat = 2;
    step();
    redirect_i = 1'b1; redirect_pc_i = 32'h0100_0102;
    step();
    redirect_i = 1'b0;
    checks++; if (dec_valid_o !== 1'b0 || imem_req_o !== 1'b0) begin errors++; $display("FAIL rw_drop: valid %b req %b want 0 0", dec_valid_o, imem_req_o); end
    step();
    checks++; if (dec_valid_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h0100_0100) begin
      errors++; $display("FAIL rw_req: valid %b req %b addr %h want 0 1 01000100", dec_valid_o, imem_req_o, imem_addr_o); end
    step(); step();
    checks++; if (dec_valid_o !== 1'b0) begin errors++; $display("FAIL rw_wait: valid %b want 0", dec_valid_o); end
    step();
    checks++; if (dec_valid_o !== 1'b1 || dec_pc_o !== 32'h0100_0100 || dec_insn_o !== 32'hDFAD_0100) begin
      errors++; $display("FAIL rw_dec: valid %b pc %h insn %h want 1 01000100 dfad0100", dec_valid_o, dec_pc_o, dec_insn_o); end
    step();
    checks++; if (imem_addr_o !== 32'h0100_0104) begin errors++; $display("FAIL rw_next: addr %h want 01000104", imem_addr_o); end
  endtask

  task automatic test_redirect_collide();
    lat = 1;
    step();
    redirect_i = 1'b1; redirect_pc_i = 32'h0200_0000;
    step();
    redirect_i = 1'b0;
    checks++; if (dec_valid_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h0200_0000) begin
      errors++; $display("FAIL collide: valid %b req %b addr %h want 0 1 02000000", dec_valid_o, imem_req_o, imem_addr_o); end
  endtask

  task automatic test_redirect_hold();
    step(); step();
    checks++; if (dec_valid_o !== 1'b1 || dec_pc_o !== 32'h0200_0000 || dec_insn_o !== 32'hDCAD_0000) begin
      errors++; $display("FAIL rh_dec: valid %b pc %h insn %h want 1 02000000 dcad0000", dec_valid_o, dec_pc_o, dec_insn_o); end
    dec_ready_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h0300_0010;
    step();
    redirect_i = 1'b0;
    checks++; if (dec_valid_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h0300_0010) begin
      errors++; $display("FAIL rh_req: valid %b req %b addr %h want 0 1 03000010", dec_valid_o, imem_req_o, imem_addr_o); end
  endtask

  task automatic test_redirect_req();
    redirect_i = 1'b1; redirect_pc_i = 32'h0300_0203;
    #1;
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0300_0010) begin
      errors++; $display("FAIL rr_issue: req %b addr %h want 1 03000010", imem_req_o, imem_addr_o); end
    step();
    redirect_i = 1'b0;
    checks++; if (imem_req_o !== 1'b0 || dec_valid_o !== 1'b0) begin errors++; $display("FAIL rr_drop: req %b valid %b want 0 0", imem_req_o, dec_valid_o); end
    step();
    checks++; if (dec_valid_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h0300_0200) begin
      errors++; $display("FAIL rr_req: valid %b req %b addr %h want 0 1 03000200", dec_valid_o, imem_req_o, imem_addr_o); end
  endtask

  task automatic test_wrap();
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFF;
    step();
    redirect_i = 1'b0;
    step();
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL wrap_align: req %b addr %h want 1 fffffffc", imem_req_o, imem_addr_o); end
    step(); step();
    checks++; if (dec_valid_o !== 1'b1 || dec_pc_o !== 32'hFFFF_FFFC || dec_insn_o !== 32'h2152_FFFC) begin
      errors++; $display("FAIL wrap_dec: valid %b pc %h insn %h want 1 fffffffc 2152fffc", dec_valid_o, dec_pc_o, dec_insn_o); end
    step();
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0000_0000) begin
      errors++; $display("FAIL wrap_zero: req %b addr %h want 1 00000000", imem_req_o, imem_addr_o); end
  endtask

  task automatic test_reset_mid();
    step();
    auto_mem = 1'b0; cnt = 0; imem_rvalid_i = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++; if (imem_req_o !== 1'b0 || dec_valid_o !== 1'b0 || dec_pc_o !== BASE || dec_insn_o !== 32'h0000_0013) begin
      errors++; $display("FAIL rm_async: req %b valid %b pc %h insn %h want 0 0 %h 00000013", imem_req_o, dec_valid_o, dec_pc_o, dec_insn_o, BASE); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== BASE) begin
      errors++; $display("FAIL rm_restart: req %b addr %h want 1 %h", imem_req_o, imem_addr_o, BASE); end
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'hBAD0_BAD0;
    step();
    imem_rvalid_i = 1'b0;
    checks++; if (dec_valid_o !== 1'b0 || dec_insn_o !== 32'h0000_0013) begin
      errors++; $display("FAIL rm_late: valid %b insn %h want 0 00000013", dec_valid_o, dec_insn_o); end
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'h1234_5678;
    step();
    imem_rvalid_i = 1'b0;
    checks++; if (dec_valid_o !== 1'b1 || dec_pc_o !== BASE || dec_insn_o !== 32'h1234_5678) begin
      errors++; $display("FAIL rm_fetch: valid %b pc %h insn %h want 1 %h 12345678", dec_valid_o, dec_pc_o, dec_insn_o, BASE); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_hold_stall();
    test_redirect_wait();
    test_redirect_collide();
    test_redirect_hold();
    test_redirect_req();
    test_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch.md
FETCH -- requirements
Module: fetch

Interface
REQ-001 The block SHALL have parameter DWIDTH, default 32, giving the instruction width.
REQ-002 The block SHALL have parameter AWIDTH, default 32, giving the address/PC width.
REQ-003 The block SHALL have parameter BASEADDR, default 32'h0100_0000, giving the reset PC.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port imem_req_o, output, 1 bit: instruction memory read request, one cycle per request.
REQ-007 The block SHALL have port imem_addr_o, output, AWIDTH bits: request address, valid while imem_req_o=1.
REQ-008 The block SHALL have port imem_rvalid_i, input, 1 bit: response valid, at least 1 cycle after the request.
REQ-009 The block SHALL have port imem_rdata_i, input, DWIDTH bits: response instruction word.
REQ-010 The block SHALL have port redirect_i, input, 1 bit: taken branch/jump from execute (PC select).
REQ-011 The block SHALL have port redirect_pc_i, input, AWIDTH bits: redirect target.
REQ-012 The block SHALL have port dec_valid_o, output, 1 bit: instruction presented to decode.
REQ-013 The block SHALL have port dec_ready_i, input, 1 bit: decode accepts this cycle.
REQ-014 The block SHALL have port dec_pc_o, output, AWIDTH bits: PC of the presented instruction.
REQ-015 The block SHALL have port dec_insn_o, output, DWIDTH bits: presented instruction.

Function
REQ-016 The block SHALL implement a four-state FSM: REQ, WAIT, HOLD, DROP.
REQ-017 In REQ, the block SHALL drive imem_req_o=1 and imem_addr_o=pc, then go to WAIT the next cycle.
REQ-018 imem_req_o SHALL be 0 in all other states; at most one request is outstanding.
REQ-019 In WAIT, on imem_rvalid_i=1 with redirect_i=0, the block SHALL:
  - register imem_rdata_i into dec_insn_o and pc into dec_pc_o;
  - set dec_valid_o=1 and pc=pc+4;
  - go to HOLD.
REQ-020 In WAIT, on redirect_i=1 with imem_rvalid_i=0, the block SHALL set pc=redirect_pc_i and go to DROP.
REQ-021 In WAIT, on redirect_i=1 and imem_rvalid_i=1 together, the block SHALL discard the response, set pc=redirect_pc_i and go to REQ.
REQ-022 In DROP, the block SHALL discard the next imem_rvalid_i response, leave dec_valid_o=0, and go to REQ; a further redirect in DROP SHALL only update pc.
REQ-023 In HOLD, dec_valid_o, dec_pc_o and dec_insn_o SHALL stay stable until dec_valid_o&&dec_ready_i; after the handshake the next cycle SHALL have dec_valid_o=0 and state REQ.
REQ-024 Redirect in HOLD SHALL take priority over the handshake: clear dec_valid_o next cycle, set pc=redirect_pc_i, go to REQ.
REQ-025 Redirect in REQ SHALL still issue that cycle's request, set pc=redirect_pc_i and go to DROP.
REQ-026 pc arithmetic SHALL be modulo 2^AWIDTH (wrap from all-ones-minus-3 to 0).
REQ-027 The block SHALL force redirect targets to 4-byte alignment by clearing bits [1:0].
REQ-028 imem_rvalid_i in REQ or HOLD (protocol error) SHALL be ignored.
REQ-029 Minimum issue rate SHALL be one instruction per 3 cycles (REQ, WAIT with 1-cycle memory, HOLD with dec_ready_i=1).

Reset
REQ-030 While rst_n=0, asynchronously:
  - pc=BASEADDR, state=REQ;
  - dec_valid_o=0, dec_pc_o=BASEADDR, dec_insn_o=32'h0000_0013 (NOP);
  - imem_req_o=0.
REQ-031 The first request SHALL be issued in the first cycle after rst_n deasserts.
REQ-032 Reset mid-request SHALL abandon the outstanding response; no late response SHALL reach decode.

Structure
REQ-033 The FSM state enum and the NOP constant SHALL live in the shared constants package/header with the existing opcode, ALU and WB encodings.
REQ-034 The block SHALL be a single module with no sub-modules; the PC register, output register and FSM are all local.

Verification
REQ-035 Scenario: reset release, 1-cycle memory, dec_ready_i=1 -> requests at 0x01000000, 0x01000004, 0x01000008; each instruction presented with the matching dec_pc_o, 3 cycles apart.
REQ-036 Scenario: dec_ready_i=0 for 5 cycles in HOLD -> dec_valid_o=1 and outputs unchanged throughout; no new imem_req_o.
REQ-037 Scenario: redirect_i=1 to 0x01000102 in WAIT, response 2 cycles later -> response dropped; next request at 0x01000100; dec_valid_o stays 0 until that response returns.
REQ-038 Scenario: redirect and imem_rvalid_i in the same WAIT cycle -> no dec_valid_o; next cycle imem_req_o=1 at the target.
REQ-039 Scenario: redirect in HOLD with dec_ready_i=1 -> handshake not counted as a fetch advance; next request at the target, not pc+4.
REQ-040 Scenario: rst_n pulsed low during WAIT -> all outputs at reset values immediately; a late imem_rvalid_i is ignored; fetch restarts at BASEADDR.
